// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings and control bundle for ctrl_pipe
package ctrl_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_NOP   = 2'b11;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       memto_reg;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_bundle_t;

    // A bubble is an invalid slot whose controls are all inactive.
    localparam ctrl_bundle_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_NOP};

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational EX operand forwarding selects
module forward_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic              valid_mem,
    input  logic              reg_write_mem,
    input  logic [REG_AW-1:0] wreg_mem,
    input  logic              valid_wb,
    input  logic              reg_write_wb,
    input  logic [REG_AW-1:0] wreg_wb,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    // The youngest producer (MEM) wins over WB; register 0 is never forwarded.
    function automatic logic [1:0] select_src(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_REG;
        if (valid_mem && reg_write_mem && (wreg_mem != '0) && (wreg_mem == src)) begin
            sel = FWD_MEM;
        end else if (valid_wb && reg_write_wb && (wreg_wb != '0) && (wreg_wb == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    assign forward_a = select_src(rs_ex);
    assign forward_b = select_src(rt_ex);

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control pipeline with hazard and forwarding logic
// Optional performance counters: CTRL_PIPE_PERF_CNT_EN
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_id,
    input  logic              RegWrite_id,
    input  logic              MemtoReg_id,
    input  logic              MemRead_id,
    input  logic              MemWrite_id,
    input  logic              RegDst_id,
    input  logic              ALUSrc_id,
    input  logic [1:0]        ALUOp_id,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              flush_id,
    input  logic              mem_ready,
    output logic [1:0]        ALUOp_ex,
    output logic              ALUSrc_ex,
    output logic              RegDst_ex,
    output logic              MemRead_mem,
    output logic              MemWrite_mem,
    output logic              MemtoReg_wb,
    output logic              RegWrite_wb,
    output logic [REG_AW-1:0] wreg_mem,
    output logic [REG_AW-1:0] wreg_wb,
    output logic              stall_id,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_bundle_t      ctrl_id;
    ctrl_bundle_t      ctrl_ex;
    logic [REG_AW-1:0] rs_ex, rt_ex, rd_ex, wreg_ex;
    logic              valid_mem, RegWrite_mem, MemtoReg_mem;
    logic              valid_wb;
    logic              load_use, bubble;

    always_comb begin
        ctrl_id           = CTRL_BUBBLE;
        ctrl_id.valid     = valid_id;
        ctrl_id.reg_write = RegWrite_id;
        ctrl_id.memto_reg = MemtoReg_id;
        ctrl_id.mem_read  = MemRead_id;
        ctrl_id.mem_write = MemWrite_id;
        ctrl_id.reg_dst   = RegDst_id;
        ctrl_id.alu_src   = ALUSrc_id;
        ctrl_id.alu_op    = ALUOp_id;
    end

    assign load_use = valid_id & ctrl_ex.valid & ctrl_ex.mem_read & (rt_ex != '0)
                    & ((rt_ex == rs_id) | (rt_ex == rt_id));
    assign stall_id = ~mem_ready | load_use;
    // Invalid ID slots enter EX as bubbles too, so every invalid stage holds zeros.
    assign bubble   = load_use | flush_id | ~valid_id;
    assign wreg_ex  = ctrl_ex.reg_dst ? rd_ex : rt_ex;

    assign ALUOp_ex  = ctrl_ex.alu_op;
    assign ALUSrc_ex = ctrl_ex.alu_src;
    assign RegDst_ex = ctrl_ex.reg_dst;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_ex      <= CTRL_BUBBLE;
            rs_ex        <= '0;
            rt_ex        <= '0;
            rd_ex        <= '0;
            valid_mem    <= 1'b0;
            RegWrite_mem <= 1'b0;
            MemtoReg_mem <= 1'b0;
            MemRead_mem  <= 1'b0;
            MemWrite_mem <= 1'b0;
            wreg_mem     <= '0;
            valid_wb     <= 1'b0;
            RegWrite_wb  <= 1'b0;
            MemtoReg_wb  <= 1'b0;
            wreg_wb      <= '0;
        end else if (mem_ready) begin
            if (bubble) begin
                ctrl_ex <= CTRL_BUBBLE;
                rs_ex   <= '0;
                rt_ex   <= '0;
                rd_ex   <= '0;
            end else begin
                ctrl_ex <= ctrl_id;
                rs_ex   <= rs_id;
                rt_ex   <= rt_id;
                rd_ex   <= rd_id;
            end
            valid_mem    <= ctrl_ex.valid;
            RegWrite_mem <= ctrl_ex.reg_write;
            MemtoReg_mem <= ctrl_ex.memto_reg;
            MemRead_mem  <= ctrl_ex.mem_read;
            MemWrite_mem <= ctrl_ex.mem_write;
            wreg_mem     <= wreg_ex;
            valid_wb     <= valid_mem;
            RegWrite_wb  <= RegWrite_mem;
            MemtoReg_wb  <= MemtoReg_mem;
            wreg_wb      <= wreg_mem;
        end
    end

    forward_unit #(
        .REG_AW(REG_AW)
    ) u_forward_unit (
        .rs_ex        (rs_ex),
        .rt_ex        (rt_ex),
        .valid_mem    (valid_mem),
        .reg_write_mem(RegWrite_mem),
        .wreg_mem     (wreg_mem),
        .valid_wb     (valid_wb),
        .reg_write_wb (RegWrite_wb),
        .wreg_wb      (wreg_wb),
        .forward_a    (ForwardA),
        .forward_b    (ForwardB)
    );

`ifdef CTRL_PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (valid_wb && mem_ready) begin
                retired_cnt <= retired_cnt + 1'b1;
            end
            if (stall_id) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized and directed self-checking bench for ctrl_pipe
module tb_ctrl_pipe;

    typedef struct {
        bit       v;
        bit       rw, m2r, mr, mw, rdst, asrc;
        bit [1:0] op;
        bit [4:0] rs, rt, rd;
    } ins_t;

    logic        clk = 1'b0;
    logic        reset, valid_id, RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id;
    logic        RegDst_id, ALUSrc_id, flush_id, mem_ready;
    logic [1:0]  ALUOp_id;
    logic [4:0]  rs_id, rt_id, rd_id;
    logic [1:0]  ALUOp_ex, ForwardA, ForwardB;
    logic        ALUSrc_ex, RegDst_ex, MemRead_mem, MemWrite_mem, MemtoReg_wb, RegWrite_wb, stall_id;
    logic [4:0]  wreg_mem, wreg_wb;
    logic [31:0] retired_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    ins_t        ex_s, mem_s, wb_s, nop_i;
    logic [31:0] m_retired, m_stall;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id),
        .RegWrite_id(RegWrite_id), .MemtoReg_id(MemtoReg_id), .MemRead_id(MemRead_id),
        .MemWrite_id(MemWrite_id), .RegDst_id(RegDst_id), .ALUSrc_id(ALUSrc_id),
        .ALUOp_id(ALUOp_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .flush_id(flush_id), .mem_ready(mem_ready),
        .ALUOp_ex(ALUOp_ex), .ALUSrc_ex(ALUSrc_ex), .RegDst_ex(RegDst_ex),
        .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
        .MemtoReg_wb(MemtoReg_wb), .RegWrite_wb(RegWrite_wb),
        .wreg_mem(wreg_mem), .wreg_wb(wreg_wb), .stall_id(stall_id),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(input bit v, rw, m2r, mr, mw, rdst, asrc, input bit [1:0] op,
                                input bit [4:0] rs, rt, rd);
        ins_t i;
        i.v = v; i.rw = rw; i.m2r = m2r; i.mr = mr; i.mw = mw; i.rdst = rdst; i.asrc = asrc;
        i.op = op; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic bit [4:0] dest(input ins_t i);
        return i.rdst ? i.rd : i.rt;
    endfunction

    // A source is forwarded from the youngest older instruction that writes it.
    function automatic bit [1:0] fwd(input bit [4:0] src);
        if (!ex_s.v || src == 0) return 2'b00;
        if (mem_s.v && mem_s.rw && dest(mem_s) == src) return 2'b10;
        if (wb_s.v && wb_s.rw && dest(wb_s) == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hazard();
        return valid_id && ex_s.v && ex_s.mr && ex_s.rt != 0 && (ex_s.rt == rs_id || ex_s.rt == rt_id);
    endfunction

    task automatic set_id(input ins_t i);
        valid_id = i.v; RegWrite_id = i.rw; MemtoReg_id = i.m2r; MemRead_id = i.mr;
        MemWrite_id = i.mw; RegDst_id = i.rdst; ALUSrc_id = i.asrc; ALUOp_id = i.op;
        rs_id = i.rs; rt_id = i.rt; rd_id = i.rd;
    endtask

    function automatic ins_t id_ins();
        return mk(valid_id, RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, RegDst_id,
                  ALUSrc_id, ALUOp_id, rs_id, rt_id, rd_id);
    endfunction

    task automatic compare_all();
        bit stall_exp;
        stall_exp = !mem_ready || hazard();
        check_eq("aluop_ex", ALUOp_ex, ex_s.v ? ex_s.op : 2'b11);
        check_eq("alusrc_ex", ALUSrc_ex, ex_s.v & ex_s.asrc);
        check_eq("regdst_ex", RegDst_ex, ex_s.v & ex_s.rdst);
        check_eq("memread_mem", MemRead_mem, mem_s.v & mem_s.mr);
        check_eq("memwrite_mem", MemWrite_mem, mem_s.v & mem_s.mw);
        check_eq("wreg_mem", wreg_mem, mem_s.v ? dest(mem_s) : 5'd0);
        check_eq("memtoreg_wb", MemtoReg_wb, wb_s.v & wb_s.m2r);
        check_eq("regwrite_wb", RegWrite_wb, wb_s.v & wb_s.rw);
        check_eq("wreg_wb", wreg_wb, wb_s.v ? dest(wb_s) : 5'd0);
        check_eq("stall_id", stall_id, stall_exp);
        check_eq("forward_a", ForwardA, fwd(ex_s.rs));
        check_eq("forward_b", ForwardB, fwd(ex_s.rt));
`ifdef CTRL_PIPE_PERF_CNT_EN
        check_eq("retired_cnt", retired_cnt, m_retired);
        check_eq("stall_cnt", stall_cnt, m_stall);
`else
        check_eq("retired_cnt", retired_cnt, 32'd0);
        check_eq("stall_cnt", stall_cnt, 32'd0);
`endif
    endtask

    // Inputs are already driven; check near mid-cycle, then advance model and clock.
    task automatic step();
        bit stall_exp;
        #3;
        compare_all();
        stall_exp = !mem_ready || hazard();
        if (reset) begin
            ex_s = nop_i; mem_s = nop_i; wb_s = nop_i;
            m_retired = 0; m_stall = 0;
        end else begin
            if (stall_exp) m_stall++;
            if (mem_ready) begin
                if (wb_s.v) m_retired++;
                wb_s  = mem_s;
                mem_s = ex_s;
                ex_s  = (hazard() || flush_id || !valid_id) ? nop_i : id_ins();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; set_id(nop_i); flush_id = 1'b0; mem_ready = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        ins_t a, lw, sw;
        nop_i = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        ex_s = nop_i; mem_s = nop_i; wb_s = nop_i;
        m_retired = 0; m_stall = 0;
        reset = 1'b1; flush_id = 1'b0; mem_ready = 1'b1; set_id(nop_i);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        check_eq("rst_aluop", ALUOp_ex, 2'b11);
        check_eq("rst_regwrite_wb", RegWrite_wb, 0);
        do_reset();

        // Straight-line forwarding: MEM then WB
        set_id(mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 1, 2, 5)); step();
        set_id(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 5, 3, 0)); step();
        check_eq("dir_fwd_mem", ForwardA, 2'b10);
        set_id(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 5, 4, 0)); step();
        check_eq("dir_fwd_wb", ForwardA, 2'b01);
        set_id(nop_i); step();

        // Load-use: one bubble then WB forward
        lw = mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 0, 8, 0);
        set_id(lw); step();
        set_id(mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 8, 1, 0)); #1;
        check_eq("dir_lu_stall", stall_id, 1);
        step(); #1;
        check_eq("dir_lu_bubble", ALUOp_ex, 2'b11);
        check_eq("dir_lu_stall_gone", stall_id, 0);
        step();
        check_eq("dir_lu_fwd_wb", ForwardA, 2'b01);
        set_id(nop_i); step();

        // Register zero is never a hazard nor forwarded
        set_id(mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 0, 0, 0)); step();
        set_id(mk(1, 0, 0, 0, 0, 0, 0, 2'b10, 0, 1, 0)); #1;
        check_eq("dir_r0_stall", stall_id, 0);
        step();
        check_eq("dir_r0_fwd", ForwardA, 2'b00);
        set_id(nop_i); step();

        // Freeze with SW in MEM
        do_reset();
        a  = mk(1, 1, 0, 0, 0, 1, 0, 2'b10, 1, 2, 9);
        sw = mk(1, 0, 0, 0, 1, 0, 1, 2'b00, 4, 3, 0);
        set_id(a); step();
        set_id(sw); step();
        set_id(nop_i); step();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("dir_frz_memwrite", MemWrite_mem, 1);
            check_eq("dir_frz_stall", stall_id, 1);
            check_eq("dir_frz_wreg_wb", wreg_wb, 9);
            check_eq("dir_frz_regwrite_wb", RegWrite_wb, 1);
            step();
        end
        mem_ready = 1'b1; step();
        check_eq("dir_resume_memwrite", MemWrite_mem, 0);
        check_eq("dir_resume_wreg_wb", wreg_wb, 3);

        // Flushed writer never reaches WB
        do_reset();
        set_id(mk(1, 1, 0, 0, 0, 1, 0, 2'b10, 1, 2, 7)); flush_id = 1'b1; step();
        flush_id = 1'b0; set_id(nop_i);
        for (int k = 0; k < 4; k++) begin
            check_eq("dir_flush_regwrite_wb", RegWrite_wb, 0);
            step();
        end

        // Reset mid-stream with three valid stages
        for (int k = 0; k < 3; k++) begin
            set_id(mk(1, 1, 1, 1, 1, 1, 1, 2'b10, 5'(k + 1), 5'(k + 2), 5'(k + 3))); step();
        end
        check_eq("dir_pre_rst_regwrite_wb", RegWrite_wb, 1);
        reset = 1'b1; set_id(nop_i); step(); reset = 1'b0;
        check_eq("dir_rst_aluop", ALUOp_ex, 2'b11);
        check_eq("dir_rst_regwrite_wb", RegWrite_wb, 0);
        check_eq("dir_rst_memread_mem", MemRead_mem, 0);
        check_eq("dir_rst_wreg_wb", wreg_wb, 0);
        check_eq("dir_rst_retired", retired_cnt, 0);

        // Randomized stream against the model
        for (int n = 0; n < 3000; n++) begin
            ins_t r;
            r = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
                   $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            set_id(r);
            flush_id  = ($urandom_range(0, 9) == 0);
            mem_ready = ($urandom_range(0, 4) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Carries the decoded control bundle from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers. The control decoder produces the bundle; this block consumes it.
Detects load-use hazards and inserts bubbles. Generates EX-stage forwarding selects.
Holds the whole back end while data memory is not ready.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
valid_id  in  1  instruction in ID is real
RegWrite_id, MemtoReg_id, MemRead_id, MemWrite_id, RegDst_id, ALUSrc_id  in  1 each  decoded controls
ALUOp_id  in  2  decoded ALU op class
rs_id, rt_id, rd_id  in  REG_AW  register fields of ID instruction
flush_id  in  1  kill instruction entering EX (branch/jump taken)
mem_ready  in  1  data memory ready; 0 freezes back end
ALUOp_ex  out  2; ALUSrc_ex, RegDst_ex  out  1  EX controls
MemRead_mem, MemWrite_mem  out  1  MEM controls
MemtoReg_wb, RegWrite_wb  out  1  WB controls
wreg_mem, wreg_wb  out  REG_AW  destination register in MEM/WB
stall_id  out  1  hold PC and IF/ID; comb.
ForwardA, ForwardB  out  2  EX operand select; comb.
retired_cnt, stall_cnt  out  CNT_W  perf counters

Behaviour:
- Reset (sync, high): all stage valids 0, all registered controls 0, wreg_* 0, ALUOp_ex 2'b11 (NOP). Comb outputs then evaluate to stall_id 0, Forward* 00.
- Latency: a bundle in ID at cycle N appears at EX outputs at N+1, MEM at N+2, WB at N+3, assuming no freeze.
- Invalid stage: all its control outputs read 0 (ALUOp_ex 11). Implement this by registering zeros, not by output gating.
- EX destination register: wreg_ex = RegDst_ex ? rd_ex : rt_ex. It is registered into wreg_mem.
- Load-use stall: stall_id = valid_id & valid_ex & MemRead_ex & (rt_ex != 0) & (rt_ex == rs_id | rt_ex == rt_id).
- On stall: ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- flush_id=1: ID/EX loads a bubble, with or without stall.
- mem_ready=0: all three stage registers hold their values and stall_id is forced to 1.
- During a freeze, RegWrite_wb stays asserted. The repeated WB write is idempotent.
- Priority: reset > freeze (mem_ready=0) > bubble (stall or flush) > advance.
- Forwarding for A, compared against rs_ex:
  - 2'b10 if valid_mem & RegWrite_mem & wreg_mem != 0 & wreg_mem == rs_ex;
  - else 2'b01 for the same test against the WB stage;
  - else 2'b00.
- Forwarding for B: same rules, compared against rt_ex.
- MEM has priority over WB. Register 0 is never forwarded.
- Reset asserted mid-stream: all in-flight instructions are discarded the next cycle. No WB write occurs after the reset edge.

Optional Feature:
CTRL_PIPE_PERF_CNT_EN
- Defined:
  - retired_cnt increments when valid_wb & mem_ready.
  - stall_cnt increments each cycle stall_id=1.
  - Both counters wrap at 2^CNT_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package ctrl_pkg:
  - ALUOp encodings: ADD 2'b00, CMP 2'b01, RTYPE 2'b10, NOP 2'b11.
  - Forward selects: FWD_REG 00, FWD_WB 01, FWD_MEM 10.
  - Packed struct ctrl_bundle_t holding the nine control bits.
- Sub-module forward_unit: purely combinational, computes ForwardA/ForwardB. Instantiated once.

Test Plan:
- Straight-line stream:
  - Stimulus: ADD with RegDst=1, rd=5, then ADD reading rs=5.
  - Response: ForwardA=10 in the second instruction's EX cycle. The following independent instruction reads rs=5 with ForwardA=01.
- Load-use:
  - Stimulus: LW with rt=8, followed by an instruction with rs=8.
  - Response: stall_id=1 for exactly one cycle, and ALUOp_ex=11 bubble. The next cycle gives ForwardA=01.
- Register zero:
  - Stimulus: LW with rt=0, followed by rs=0.
  - Response: stall_id=0 and ForwardA=00.
- Freeze:
  - Stimulus: mem_ready=0 for 3 cycles with SW in MEM.
  - Response: MemWrite_mem=1 held for 3 cycles, stall_id=1, wreg_wb unchanged. Pipeline resumes on the cycle after mem_ready returns to 1.
- Flush plus reset:
  - Stimulus: flush_id together with a valid RegWrite instruction.
  - Response: that instruction never raises RegWrite_wb.
  - Stimulus: reset asserted with 3 valid stages.
  - Response: next cycle all outputs are at reset values, and retired_cnt=0 when the feature is enabled.
